// File: rtl/adder_27_feeder.sv
// rtl/adder_27_feeder.sv - packs a serial operand stream into the 27-input adder bus and returns its sum
// Optional watchdog in WAIT: define FEEDER_TIMEOUT_EN.
module adder_27_feeder #(
    parameter int BITSIZE     = 14,
    parameter int NUM_INPUTS  = 27,
    parameter int SUM_W       = BITSIZE + 7,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [BITSIZE-1:0]            in_data,
    output logic                          in_ready,
    output logic [NUM_INPUTS*BITSIZE-1:0] input_numbers,
    output logic                          start_adder,
    input  logic [SUM_W-1:0]              adder_sum,
    input  logic                          adder_valid,
    output logic                          out_valid,
    output logic [SUM_W-1:0]              out_sum,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int CNT_W = $clog2(NUM_INPUTS);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign in_ready    = (state == S_LOAD);
    assign start_adder = (state == S_FIRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_LOAD;
            cnt           <= '0;
            input_numbers <= '0;
            out_valid     <= 1'b0;
            out_sum       <= '0;
            busy          <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            wait_cnt      <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
`ifdef FEEDER_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        input_numbers[int'(cnt)*BITSIZE +: BITSIZE] <= in_data;
                        busy <= 1'b1;
                        if (cnt == CNT_W'(NUM_INPUTS - 1)) begin
                            cnt   <= '0;
                            state <= S_FIRE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FIRE: begin
`ifdef FEEDER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (adder_valid) begin
                        out_sum   <= adder_sum;
                        out_valid <= 1'b1;
                        state     <= S_HOLD;
                    end
`ifdef FEEDER_TIMEOUT_EN
                    // Give up after TIMEOUT_CYC silent cycles; out_sum keeps the last good result.
                    else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_27_feeder.sv
// tb/tb_adder_27_feeder.sv - scoreboard bench for adder_27_feeder with a latency-5 adder model
module tb_adder_27_feeder;
    localparam int BW = 14;
    localparam int N  = 27;
    localparam int SW = BW + 7;
    localparam int L  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [BW-1:0]   in_data;
    logic            in_ready;
    logic [N*BW-1:0] input_numbers;
    logic            start_adder;
    logic [SW-1:0]   adder_sum;
    logic            adder_valid;
    logic            out_valid;
    logic [SW-1:0]   out_sum;
    logic            out_ready;
    logic            busy;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;
    logic [SW-1:0] exp_q[$];
    logic [BW-1:0] win[N];
    int starts = 0;
    bit no_adder = 0;
    int pend = 0;
    logic [SW-1:0] pend_sum = '0;

    always #5 clk = ~clk;

    adder_27_feeder #(.BITSIZE(BW), .NUM_INPUTS(N), .SUM_W(SW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .input_numbers(input_numbers), .start_adder(start_adder), .adder_sum(adder_sum),
        .adder_valid(adder_valid), .out_valid(out_valid), .out_sum(out_sum),
        .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err)
    );

    assign adder_sum = pend_sum;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] slot_sum();
        logic [SW-1:0] s = '0;
        logic signed [BW-1:0] v;
        for (int i = 0; i < N; i++) begin
            v = input_numbers[i*BW +: BW];
            s = s + SW'(v);
        end
        return s;
    endfunction

    // Adder model: sums the bus present at start, raises valid L cycles later.
    always @(negedge clk) begin
        adder_valid = 1'b0;
        if (pend != 0) begin
            pend = pend - 1;
            if (pend == 0) adder_valid = 1'b1;
        end
        if (start_adder) begin
            starts++;
            if (!no_adder) begin
                pend     = L;
                pend_sum = slot_sum();
            end
        end
    end

    // Result monitor
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", out_sum);
            end else begin
                check("out_sum", out_sum, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [BW-1:0] d);
        bit acc = 0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: got timeout expected accept");
        end
    endtask

    task automatic send_window(input bit bubbles);
        for (int i = 0; i < N; i++) begin
            if (bubbles) repeat ($urandom_range(0, 2)) tick();
            send_beat(win[i]);
        end
    endtask

    task automatic check_slots();
        for (int i = 0; i < N; i++)
            check($sformatf("slot%0d", i), input_numbers[i*BW +: BW], win[i]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int s0;
        int n;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_start", start_adder, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bus_zero", input_numbers == '0, 1);
        check("rst_timeout", timeout_err, 0);

        // Constant window 3.25 x 27 = 11232
        for (int i = 0; i < N; i++) win[i] = 14'h01A0;
        exp_q.push_back(21'h002BE0);
        s0 = starts;
        send_window(0);
        check("start_after_last", start_adder, 1);
        check_slots();
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        check("result_latency", n, 6);
        wait_drain();
        check("start_count", starts - s0, 1);

        // Ordering with bubbles: -2*i, total -756
        for (int i = 0; i < N; i++) win[i] = BW'(-2 * (i + 1));
        exp_q.push_back(21'h1FFD0C);
        send_window(1);
        check_slots();
        wait_drain();

        // Backpressure in HOLD: 1..27, total 378
        for (int i = 0; i < N; i++) win[i] = BW'(i + 1);
        exp_q.push_back(21'h00017A);
        out_ready = 1'b0;
        send_window(0);
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        s0 = starts;
        repeat (10) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_sum", out_sum, 21'h00017A);
            check("bp_in_ready", in_ready, 0);
        end
        check("bp_no_start", starts - s0, 0);
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        wait_drain();

        // Reset mid-load, then a clean window of 1.0 x 27 = 3456
        for (int i = 0; i < 13; i++) send_beat(14'h1FFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_bus_zero", input_numbers == '0, 1);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < N; i++) win[i] = 14'h0080;
        exp_q.push_back(21'h000D80);
        send_window(0);
        wait_drain();

        // Adder never answers
        no_adder = 1;
        for (int i = 0; i < N; i++) win[i] = 14'h0001;
        send_window(0);
`ifdef FEEDER_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 40) begin tick(); n++; end
        check("timeout_cycle", n, 17);
        check("timeout_in_ready", in_ready, 1);
        check("timeout_out_valid", out_valid, 0);
        check("timeout_out_sum_kept", out_sum, 21'h000D80);
        tick();
        check("timeout_one_pulse", timeout_err, 0);
`else
        seen = 0;
        repeat (40) begin
            tick();
            if (timeout_err) seen = 1;
        end
        check("no_timeout", seen, 0);
        check("wait_in_ready", in_ready, 0);
        check("wait_busy", busy, 1);
        check("wait_out_valid", out_valid, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("recover_in_ready", in_ready, 1);
`endif
        no_adder = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got hang expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
